alu_issue_reg: RTL and testbench
================================

# alu_issue_reg

Pipeline register that sits directly upstream of the ALU. It captures decoded operands from the decode stage and resolves read-after-write hazards by forwarding from the EX and WB result buses. It holds a single instruction under a valid/ready handshake and presents `a`, `b` and `alu_control` to the ALU. While an instruction is stalled, the block keeps its operands current by snooping the WB bus.

## Interface
- `XLEN`, 32: datapath width.
- `RIDX`, 5: register-index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: decode stage offers an instruction.
- `in_ready` out 1: block accepts the instruction this cycle.
- `rs1_idx`, `rs2_idx` in RIDX: source register indices.
- `rs1_data`, `rs2_data` in XLEN: register-file read data.
- `imm` in XLEN: sign-extended immediate.
- `use_imm` in 1: `b` is taken from `imm` instead of rs2.
- `alu_ctl_in` in 3: ALU function select (000 add, 001 sub, 010 not, 011 shl, 100 shr, 101 and, 110 or).
- `rd_idx_in` in RIDX: destination index.
- `rd_we_in` in 1: destination write enable.
- `ex_we` in 1, `ex_rd` in RIDX, `ex_data` in XLEN: EX-stage result bus.
- `wb_we` in 1, `wb_rd` in RIDX, `wb_data` in XLEN: WB-stage result bus.
- `flush` in 1: kill the held instruction and any instruction offered this cycle.
- `out_valid` out 1: the held instruction is valid.
- `out_ready` in 1: the downstream stage consumes the held instruction.
- `a`, `b` out XLEN: ALU operands.
- `alu_control` out 3: ALU function select.
- `rd_idx` out RIDX, `rd_we` out 1: destination, passed through to the downstream stage.
- `stall_count` out 16: saturating count of stall cycles.

## Operation
- `in_ready = !out_valid || out_ready` (combinational). Capture happens when `in_valid && in_ready && !flush`.
- **Forwarding at capture**, rs1 and rs2 resolved independently:
  - Priority is EX, then WB, then register-file data.
  - A source matches a bus when `*_we` is set, the bus index equals the source index, and the source index is nonzero.
  - Index 0 is never forwarded; rs1/rs2 data for index 0 is passed through from the register file unmodified.
- `b` is taken from `imm` when `use_imm` is set, otherwise from the forwarded rs2 value. The block stores `rs1_idx`, `rs2_idx`, and a flag `b_is_reg = !use_imm`.
- **Hold snoop**: while `out_valid && !out_ready`, the block checks the WB bus each cycle.
  - If `wb_we` is set, `wb_rd != 0` and `wb_rd` equals the stored rs1 index, `a` is updated to `wb_data`.
  - The same check applies to `b` using the stored rs2 index, only when `b_is_reg` is set.
  - The EX bus is not snooped during hold.
- **Shift masking**: when `alu_control` is 011 or 100, the `b` output is `{0, b_reg[$clog2(XLEN)-1:0]}`. This is decoded combinationally from the registered `alu_control`. All other ports are driven directly from registers.
- **State**: a single flag `out_valid` encodes two states.
  - EMPTY → FULL on capture.
  - FULL → FULL on capture with `out_ready` (back-to-back transfer).
  - FULL → EMPTY when `out_ready` is set and there is no capture.
  - Any state → EMPTY on `flush`.
- **Flush priority**:
  - `flush` overrides both capture and `out_ready`.
  - The instruction offered in the flush cycle is dropped, even though `in_ready` may be 1.
  - Payload registers are not cleared by flush.
- **`stall_count`**: increments by 1 each cycle in which `out_valid && !out_ready && !flush`. It saturates at 16'hFFFF and is cleared only by `rst`.

## Timing
- On reset, all outputs clear asynchronously: `out_valid`=0, `a`=0, `b`=0, `alu_control`=000, `rd_idx`=0, `rd_we`=0, `stall_count`=0. Reset released mid-handshake leaves the block EMPTY with `in_ready`=1.
- Latency is 1 cycle: an instruction captured at edge N appears on the outputs with `out_valid` after edge N.
- Throughput is one instruction per cycle when `out_ready` is held high.
- Forwarding samples the EX/WB buses in the capture cycle only. The snoop sample takes effect at the next edge.
- When a WB write and a capture occur in the same cycle for a held instruction being consumed, the new instruction wins. No snoop is applied to the incoming entry beyond normal forwarding.

## Test plan
- **Reset mid-stall**:
  - Stimulus: with `out_valid`=1 and `stall_count`=5, assert `rst`.
  - Required: all outputs 0 immediately, without waiting for a clock edge; `in_ready`=1.
- **Forward priority**:
  - Stimulus: `rs1_idx`=3, `rs1_data`=1; `ex_we`=1, `ex_rd`=3, `ex_data`=0xAA; `wb_we`=1, `wb_rd`=3, `wb_data`=0xBB.
  - Required: `a`=0xAA one cycle later.
  - Repeat with `rs1_idx`=0 and the buses pointing at index 0: `a`=1.
- **Hold snoop**:
  - Stimulus: capture `rs2_idx`=7, `use_imm`=0, `b`=0x10; hold `out_ready`=0; next cycle drive `wb_we`=1, `wb_rd`=7, `wb_data`=0x55.
  - Required: `b`=0x55 and `stall_count`=2 after two stall cycles.
  - Repeat with `use_imm`=1: `b` is unchanged.
- **Shift mask**:
  - Stimulus: `alu_ctl_in`=011, `use_imm`=1, `imm`=0x0000_0123.
  - Required: `b`=0x03.
  - Repeat with `alu_ctl_in`=000: `b`=0x123.
- **Flush collision**:
  - Stimulus: `out_valid`=1, `in_valid`=1, `out_ready`=1, `flush`=1 in the same cycle.
  - Required: `out_valid`=0 next cycle; the incoming instruction never appears on the outputs.
- **Streaming and saturation**:
  - Stimulus: 8 back-to-back instructions with `out_ready`=1; then hold `out_ready`=0 for 70000 cycles.
  - Required: the 8 instructions come out in order with no bubbles; `stall_count` stops at 0xFFFF.

Source files
------------

// File: rtl/alu_issue_reg.sv
// Purpose: single-entry ALU issue register with EX/WB operand forwarding and WB snoop while held.
// Latency: 1 cycle from capture to out_valid; one instruction per cycle when out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; a held entry stalls and keeps snooping WB.
module alu_issue_reg #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst,

    // decode-stage offer
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RIDX-1:0] rs1_idx,
    input  logic [RIDX-1:0] rs2_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [2:0]      alu_ctl_in,
    input  logic [RIDX-1:0] rd_idx_in,
    input  logic            rd_we_in,

    // result buses
    input  logic            ex_we,
    input  logic [RIDX-1:0] ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            wb_we,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,

    input  logic            flush,

    // ALU side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic [2:0]      alu_control,
    output logic [RIDX-1:0] rd_idx,
    output logic            rd_we,
    output logic [15:0]     stall_count
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [2:0] ALU_SHL = 3'b011;
    localparam logic [2:0] ALU_SHR = 3'b100;

    // held payload
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [RIDX-1:0] rs1_q;
    logic [RIDX-1:0] rs2_q;
    logic            b_is_reg;

    // control
    logic            capture;
    logic            holding;
    logic            snoop_a;
    logic            snoop_b;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic [XLEN-1:0] b_next;
    logic            is_shift;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign holding  = out_valid && !out_ready;

    // Resolve rs1 at capture: EX beats WB beats register file; x0 never forwards.
    always_comb begin
        rs1_fwd = rs1_data;
        if (rs1_idx != '0) begin
            if (ex_we && (ex_rd == rs1_idx)) begin
                rs1_fwd = ex_data;
            end else if (wb_we && (wb_rd == rs1_idx)) begin
                rs1_fwd = wb_data;
            end
        end
    end

    // Resolve rs2 at capture with the same priority, then pick immediate or register for b.
    always_comb begin
        rs2_fwd = rs2_data;
        if (rs2_idx != '0) begin
            if (ex_we && (ex_rd == rs2_idx)) begin
                rs2_fwd = ex_data;
            end else if (wb_we && (wb_rd == rs2_idx)) begin
                rs2_fwd = wb_data;
            end
        end
        b_next = use_imm ? imm : rs2_fwd;
    end

    // A stalled entry only watches WB; EX results for it will reappear on WB later.
    assign snoop_a = holding && wb_we && (wb_rd != '0) && (wb_rd == rs1_q);
    assign snoop_b = holding && wb_we && (wb_rd != '0) && (wb_rd == rs2_q) && b_is_reg;

    // Occupancy flag: flush wins over everything, otherwise fill on capture or drain on consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload: load on capture, otherwise refresh operands from WB while stalled; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            alu_control <= 3'b000;
            rd_idx      <= '0;
            rd_we       <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            b_is_reg    <= 1'b0;
        end else if (capture) begin
            a_reg       <= rs1_fwd;
            b_reg       <= b_next;
            alu_control <= alu_ctl_in;
            rd_idx      <= rd_idx_in;
            rd_we       <= rd_we_in;
            rs1_q       <= rs1_idx;
            rs2_q       <= rs2_idx;
            b_is_reg    <= !use_imm;
        end else begin
            if (snoop_a) begin
                a_reg <= wb_data;
            end
            if (snoop_b) begin
                b_reg <= wb_data;
            end
        end
    end

    // Saturating count of cycles spent holding a valid entry the ALU would not take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 16'h0000;
        end else if (holding && !flush && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'h0001;
        end
    end

    // Shifts only consume the low log2(XLEN) bits of b, so the rest is masked off at the port.
    assign is_shift = (alu_control == ALU_SHL) || (alu_control == ALU_SHR);
    assign a        = a_reg;
    assign b        = is_shift ? {{(XLEN-SHW){1'b0}}, b_reg[SHW-1:0]} : b_reg;

endmodule

// File: tb/tb_alu_issue_reg.sv
// Purpose: directed plus randomized check of alu_issue_reg against a queue-based reference model.
// Latency: expects outputs one edge after capture.
// Backpressure: drives out_ready/flush randomly and checks in_ready every cycle.
module tb_alu_issue_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  alu_ctl_in;
    logic [4:0]  rd_idx_in;
    logic        rd_we_in;
    logic        ex_we;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu_control;
    logic [4:0]  rd_idx;
    logic        rd_we;
    logic [15:0] stall_count;

    alu_issue_reg #(.XLEN(32), .RIDX(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .use_imm     (use_imm),
        .alu_ctl_in  (alu_ctl_in),
        .rd_idx_in   (rd_idx_in),
        .rd_we_in    (rd_we_in),
        .ex_we       (ex_we),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .rd_idx      (rd_idx),
        .rd_we       (rd_we),
        .stall_count (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        breg;
    } instr_t;

    instr_t held[$];
    int     m_stall;
    int     passed;
    int     total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return rf;
        if (ex_we && ex_rd == idx) return ex_data;
        if (wb_we && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    function automatic logic [31:0] shown_b(input instr_t e);
        if (e.ctl == 3'd3 || e.ctl == 3'd4) return e.b % 32;
        return e.b;
    endfunction

    // Compare against the model at the falling edge, then advance the model by one cycle.
    task automatic step();
        instr_t e;
        logic   rdy;
        @(negedge clk);
        rdy = (held.size() == 0) || out_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, held.size() != 0});
        chk("stall_count", {16'd0, stall_count}, m_stall);
        if (held.size() != 0) begin
            chk("a", a, held[0].a);
            chk("b", b, shown_b(held[0]));
            chk("alu_control", {29'd0, alu_control}, {29'd0, held[0].ctl});
            chk("rd_idx", {27'd0, rd_idx}, {27'd0, held[0].rd});
            chk("rd_we", {31'd0, rd_we}, {31'd0, held[0].we});
        end
        if (held.size() != 0 && !out_ready && !flush && m_stall < 65535) m_stall++;
        if (flush) begin
            held.delete();
        end else begin
            if (held.size() != 0 && !out_ready && wb_we && wb_rd != 0) begin
                if (wb_rd == held[0].rs1) held[0].a = wb_data;
                if (wb_rd == held[0].rs2 && held[0].breg) held[0].b = wb_data;
            end
            if (held.size() != 0 && out_ready) void'(held.pop_front());
            if (in_valid && rdy) begin
                e.a    = fwd_val(rs1_idx, rs1_data);
                e.b    = use_imm ? imm : fwd_val(rs2_idx, rs2_data);
                e.ctl  = alu_ctl_in;
                e.rd   = rd_idx_in;
                e.we   = rd_we_in;
                e.rs1  = rs1_idx;
                e.rs2  = rs2_idx;
                e.breg = !use_imm;
                held.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; rs1_idx = 0; rs2_idx = 0; rs1_data = 0; rs2_data = 0;
        imm = 0; use_imm = 0; alu_ctl_in = 0; rd_idx_in = 0; rd_we_in = 0;
        ex_we = 0; ex_rd = 0; ex_data = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        flush = 0; out_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        held.delete();
        m_stall = 0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        m_stall = 0;
        rst = 1;
        idle_inputs();
        #2;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset a", a, 32'd0);
        chk("reset b", b, 32'd0);
        chk("reset stall_count", {16'd0, stall_count}, 32'd0);
        do_reset();

        // Reset mid-stall: outputs must clear without a clock edge.
        in_valid = 1; rs1_idx = 2; rs1_data = 32'h1234; imm = 32'h77; use_imm = 1;
        alu_ctl_in = 3'd5; rd_idx_in = 5'd9; rd_we_in = 1;
        step();
        in_valid = 0;
        repeat (5) step();
        chk("stall before reset", {16'd0, stall_count}, 32'd5);
        chk("valid before reset", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1;
        #1;
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async a", a, 32'd0);
        chk("async b", b, 32'd0);
        chk("async alu_control", {29'd0, alu_control}, 32'd0);
        chk("async rd_idx", {27'd0, rd_idx}, 32'd0);
        chk("async rd_we", {31'd0, rd_we}, 32'd0);
        chk("async stall_count", {16'd0, stall_count}, 32'd0);
        chk("async in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1;
        @(posedge clk);
        #1;
        rst = 0;
        #1;
        chk("release empty", {31'd0, out_valid}, 32'd0);
        chk("release in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 0;
        held.delete();
        m_stall = 0;
        step();

        // Forward priority: EX beats WB beats register file.
        do_reset();
        in_valid = 1; rs1_idx = 3; rs1_data = 1; ex_we = 1; ex_rd = 3; ex_data = 32'hAA;
        wb_we = 1; wb_rd = 3; wb_data = 32'hBB; out_ready = 1;
        step();
        chk("fwd ex priority", a, 32'hAA);
        rs1_idx = 0; ex_rd = 0; wb_rd = 0;
        step();
        chk("fwd x0 passthrough", a, 32'h1);
        in_valid = 0; ex_we = 0; wb_we = 0;
        step();

        // Hold snoop updates a register-sourced b.
        do_reset();
        in_valid = 1; rs2_idx = 7; rs2_data = 32'h10; use_imm = 0;
        step();
        in_valid = 0;
        step();
        wb_we = 1; wb_rd = 7; wb_data = 32'h55;
        step();
        wb_we = 0;
        chk("snoop b", b, 32'h55);
        chk("snoop stall_count", {16'd0, stall_count}, 32'd2);
        step();

        // Immediate-sourced b ignores the snoop.
        do_reset();
        in_valid = 1; rs2_idx = 7; rs2_data = 32'h99; imm = 32'h10; use_imm = 1;
        step();
        in_valid = 0;
        step();
        wb_we = 1; wb_rd = 7; wb_data = 32'h55;
        step();
        wb_we = 0;
        chk("imm b unchanged", b, 32'h10);
        chk("imm stall_count", {16'd0, stall_count}, 32'd2);

        // Shift masking of b.
        do_reset();
        out_ready = 1; in_valid = 1; use_imm = 1; imm = 32'h0000_0123; alu_ctl_in = 3'b011;
        step();
        chk("shift mask shl", b, 32'h03);
        alu_ctl_in = 3'b000;
        step();
        chk("no mask add", b, 32'h123);
        alu_ctl_in = 3'b100;
        step();
        chk("shift mask shr", b, 32'h03);
        in_valid = 0;
        step();

        // Flush collision: neither held nor offered instruction survives.
        do_reset();
        in_valid = 1; rd_idx_in = 5'd4; out_ready = 0;
        step();
        rd_idx_in = 5'd31; out_ready = 1; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) step();

        // Randomized traffic with frequent index collisions.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            rs1_idx    = 5'($urandom_range(0, 3));
            rs2_idx    = 5'($urandom_range(0, 3));
            rs1_data   = $urandom;
            rs2_data   = $urandom;
            imm        = $urandom;
            use_imm    = $urandom_range(0, 1) == 1;
            alu_ctl_in = 3'($urandom_range(0, 6));
            rd_idx_in  = 5'($urandom_range(0, 31));
            rd_we_in   = $urandom_range(0, 1) == 1;
            ex_we      = $urandom_range(0, 1) == 1;
            ex_rd      = 5'($urandom_range(0, 3));
            ex_data    = $urandom;
            wb_we      = $urandom_range(0, 1) == 1;
            wb_rd      = 5'($urandom_range(0, 3));
            wb_data    = $urandom;
            step();
        end

        // Streaming: eight back-to-back instructions with no bubbles.
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; rd_idx_in = 5'(i + 1); rs1_data = 32'(i * 3); alu_ctl_in = 3'd0;
            step();
            chk("stream valid", {31'd0, out_valid}, 32'd1);
            chk("stream order", {27'd0, rd_idx}, 32'(i + 1));
            chk("stream a", a, 32'(i * 3));
        end
        in_valid = 0;
        step();

        // Saturation of the stall counter.
        in_valid = 1; out_ready = 0; rd_idx_in = 5'd12;
        step();
        in_valid = 0;
        repeat (70000) @(posedge clk);
        #1;
        m_stall = 65535;
        chk("stall saturate", {16'd0, stall_count}, 32'h0000FFFF);
        chk("still valid", {31'd0, out_valid}, 32'd1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
